dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / sensor-DMA) arbiter for a single-port synchronous data memory.
// Optional macro DMEM_ARB_RR_EN: round-robin on idle contention instead of CPU-first.
//
// state  | meaning
// IDLE   | normal arbitration between CPU and sensor
// LOCK_S | sensor burst lock; CPU starvation bounded by MAX_HOLD
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              s_req,
  input  logic              s_we,
  input  logic              s_lock,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_S = 1'b1;

  typedef enum logic [0:0] {IDLE, LOCK_S} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          rd_pending;
  logic          rd_owner;
  logic          contend_s;
  logic          lock_exit;
  logic          rd_gnt;

`ifdef DMEM_ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt <= OWN_S;
    end else if (c_gnt || s_gnt) begin
      last_gnt <= s_gnt ? OWN_S : OWN_C;
    end
  end

  assign contend_s = (last_gnt == OWN_C);
`else
  assign contend_s = 1'b0;
`endif

  // Forced exit only happens with c_req high, so the CPU always takes the exit cycle.
  assign lock_exit = !s_lock || !s_req || ((hold_cnt == HOLD_MAX) && c_req);

  always_comb begin
    c_gnt = 1'b0;
    s_gnt = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (c_req && s_req) begin
            c_gnt = !contend_s;
            s_gnt = contend_s;
          end else begin
            c_gnt = c_req;
            s_gnt = s_req;
          end
        end
        LOCK_S: begin
          if (lock_exit) begin
            c_gnt = c_req;
            s_gnt = s_req && !c_req;
          end else begin
            s_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_gnt = (c_gnt && !c_we) || (s_gnt && !s_we);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_C;
    end else begin
      rd_pending <= rd_gnt;
      if (rd_gnt) rd_owner <= s_gnt ? OWN_S : OWN_C;
      case (state)
        IDLE: begin
          if (s_gnt && s_lock) begin
            state    <= LOCK_S;
            hold_cnt <= HW'(1);
          end
        end
        LOCK_S: begin
          if (lock_exit) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (c_req && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = c_gnt || s_gnt;
  assign mem_we    = c_gnt ? c_we    : (s_gnt ? s_we    : 1'b0);
  assign mem_addr  = c_gnt ? c_addr  : (s_gnt ? s_addr  : '0);
  assign mem_wdata = c_gnt ? c_wdata : (s_gnt ? s_wdata : '0);

  // Return routing follows the owner latched at grant time, not the current grant.
  assign c_rvalid = rd_pending && (rd_owner == OWN_C);
  assign s_rvalid = rd_pending && (rd_owner == OWN_S);
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign s_rdata  = s_rvalid ? mem_rdata : '0;

endmodule
